fetch_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register; sits directly upstream of the instruction decoder.
- Holds the word-addressed PC and drives the instruction memory address.
- Captures the 16-bit instruction word and its PC into the IF/ID register, with a valid flag.
- Handles stall from hazard logic, redirect from branch resolution, and the HALT opcode (4'hF, unused by the decoder).

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read port plus the IF/ID register outputs.
// master = fetch stage (drives the address and IF/ID), slave = memory/decoder side.
interface fetch_stage_if #(
   parameter int unsigned PC_WIDTH = 8
);
   logic [PC_WIDTH-1:0] imem_addr;
   logic [15:0]         imem_rdata;
   logic                if_id_valid;
   logic [15:0]         if_id_instr;
   logic [PC_WIDTH-1:0] if_id_pc;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output if_id_valid,
      output if_id_instr,
      output if_id_pc
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  if_id_valid,
      input  if_id_instr,
      input  if_id_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: word-addressed PC, combinational instruction-memory read and the
// IF/ID pipeline register. Handles stall, branch redirect and the HALT opcode.
// Per-cycle priority is redirect > stall > halt detection > normal fetch.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_count/stall_count outputs.
module fetch_stage #(
   parameter int unsigned         PC_WIDTH    = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   fetch_stage_if.master       bus,
   output logic                halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]         fetch_count,
   output logic [15:0]         stall_count
`endif
);

   typedef enum logic {RUN, HALT} state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                valid_q, valid_d;
   logic [15:0]         instr_q, instr_d;
   logic [PC_WIDTH-1:0] ifpc_q, ifpc_d;
   logic                fetch_inc;
   logic                stall_inc;

   assign bus.imem_addr   = pc_q;
   assign bus.if_id_valid = valid_q;
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc    = ifpc_q;
   assign halted          = (state_q == HALT);

   // Next-state for PC, IF/ID register and RUN/HALT state; default is hold.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      valid_d   = valid_q;
      instr_d   = instr_q;
      ifpc_d    = ifpc_q;
      fetch_inc = 1'b0;
      stall_inc = 1'b0;
      if (redirect) begin
         state_d = RUN;
         pc_d    = redirect_pc;
         valid_d = 1'b0;
         instr_d = '0;
         ifpc_d  = '0;
      end else if (state_q == RUN) begin
         if (stall) begin
            stall_inc = 1'b1;
         end else if (bus.imem_rdata[15:12] == HALT_OPCODE) begin
            // PC stays on the HALT word; it never reaches the decoder.
            state_d = HALT;
            valid_d = 1'b0;
            instr_d = '0;
         end else begin
            instr_d   = bus.imem_rdata;
            ifpc_d    = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 1'b1;
            fetch_inc = 1'b1;
         end
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= '0;
         ifpc_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fcnt_q, fcnt_d;
   logic [15:0] scnt_q, scnt_d;

   // Saturating performance counters.
   always_comb begin
      fcnt_d = fcnt_q;
      scnt_d = scnt_q;
      if (fetch_inc && (fcnt_q != '1)) fcnt_d = fcnt_q + 16'd1;
      if (stall_inc && (scnt_q != '1)) scnt_d = scnt_q + 16'd1;
   end

   // Counter registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q <= '0;
         scnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
         scnt_q <= scnt_d;
      end
   end

   assign fetch_count = fcnt_q;
   assign stall_count = scnt_q;
`else
   logic unused_perf;
   assign unused_perf = fetch_inc ^ stall_inc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed sequence for fetch_stage. A small reference model
// predicts each cycle's outputs, pushes them to a queue before the edge and the
// entry is popped and compared 1 ns after the edge.
module tb_fetch_stage;
   localparam int unsigned PW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic          redirect = 1'b0;
   logic [PW-1:0] redirect_pc = '0;
   logic          halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0]   fetch_count;
   logic [15:0]   stall_count;
`endif

   fetch_stage_if #(.PC_WIDTH(PW)) fif ();

   logic [15:0] mem [256];
   assign fif.imem_rdata = mem[fif.imem_addr];

   fetch_stage #(
      .PC_WIDTH(PW),
      .RESET_PC(8'h00),
      .HALT_OPCODE(4'hF)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .bus(fif),
      .halted(halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count(fetch_count),
      .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic [15:0]   instr;
      logic [PW-1:0] ifpc;
      logic [PW-1:0] pc;
      logic          h;
      logic [15:0]   fc;
      logic [15:0]   sc;
   } exp_t;

   exp_t q[$];

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [PW-1:0] m_pc;
   logic          m_h;
   logic          m_v;
   logic [15:0]   m_instr;
   logic [PW-1:0] m_ifpc;
   int            m_fc;
   int            m_sc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_h = 1'b0; m_v = 1'b0; m_instr = '0; m_ifpc = '0;
      m_fc = 0; m_sc = 0;
   endtask

   // One clock: predict, push, wait for the edge, pop and compare.
   task automatic step();
      exp_t        e;
      exp_t        g;
      logic [15:0] w;
      w = mem[m_pc];
      if (redirect) begin
         m_pc = redirect_pc; m_v = 1'b0; m_instr = '0; m_ifpc = '0; m_h = 1'b0;
      end else if (m_h) begin
         // halted: everything frozen
      end else if (stall) begin
         if (m_sc < 65535) m_sc++;
      end else if (w[15:12] == 4'hF) begin
         m_h = 1'b1; m_v = 1'b0; m_instr = '0;
      end else begin
         m_instr = w; m_ifpc = m_pc; m_v = 1'b1; m_pc = m_pc + 1'b1;
         if (m_fc < 65535) m_fc++;
      end
      e.v = m_v; e.instr = m_instr; e.ifpc = m_ifpc; e.pc = m_pc; e.h = m_h;
      e.fc = 16'(m_fc); e.sc = 16'(m_sc);
      q.push_back(e);
      @(posedge clk);
      #1;
      g = q.pop_front();
      chk("if_id_valid", fif.if_id_valid, g.v);
      chk("if_id_instr", fif.if_id_instr, g.instr);
      chk("if_id_pc", fif.if_id_pc, g.ifpc);
      chk("imem_addr", fif.imem_addr, g.pc);
      chk("halted", halted, g.h);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, g.fc);
      chk("stall_count", stall_count, g.sc);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 | i);
      mem[0] = 16'h0105;
      mem[1] = 16'h2340;
      mem[2] = 16'h3207;
      mem[5] = 16'hF000;
      model_reset();

      // reset values
      #2;
      chk("rst_valid", fif.if_id_valid, 1'b0);
      chk("rst_instr", fif.if_id_instr, 16'h0000);
      chk("rst_ifpc", fif.if_id_pc, 8'h00);
      chk("rst_pc", fif.imem_addr, 8'h00);
      chk("rst_halted", halted, 1'b0);
      #5 rst_n = 1'b1;

      // straight-line fetch, one per cycle
      step(); chk("seq0_instr", fif.if_id_instr, 16'h0105);
      step(); chk("seq1_instr", fif.if_id_instr, 16'h2340);
      chk("seq1_pc", fif.if_id_pc, 8'h01);

      // stall for 3 cycles: everything held
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", fif.imem_addr, 8'h02);
         chk("stall_instr", fif.if_id_instr, 16'h2340);
      end
      stall = 1'b0;
      step(); chk("resume_instr", fif.if_id_instr, 16'h3207);

      // redirect wins over a simultaneous stall
      redirect = 1'b1; redirect_pc = 8'h40; stall = 1'b1;
      step(); chk("redir_bubble", fif.if_id_valid, 1'b0);
      chk("redir_pc", fif.imem_addr, 8'h40);
      redirect = 1'b0; stall = 1'b0;
      step(); chk("redir_target", fif.if_id_pc, 8'h40);

      // run into the HALT word at address 5
      redirect = 1'b1; redirect_pc = 8'h03;
      step();
      redirect = 1'b0;
      step(); step(); step();
      chk("halt_flag", halted, 1'b1);
      chk("halt_pc", fif.imem_addr, 8'h05);
      for (int i = 0; i < 10; i++) begin
         stall = (i % 2 == 0);
         step();
      end
      stall = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h10;
      step(); chk("unhalt", halted, 1'b0);
      redirect = 1'b0;
      step(); chk("unhalt_fetch", fif.if_id_pc, 8'h10);

      // redirect beats a HALT word fetched in the same cycle
      redirect = 1'b1; redirect_pc = 8'h05;
      step();
      redirect_pc = 8'h20;
      step(); chk("redir_over_halt", halted, 1'b0);
      redirect = 1'b0;
      step();

      // PC wraps from 0xFF to 0x00
      redirect = 1'b1; redirect_pc = 8'hFE;
      step();
      redirect = 1'b0;
      step(); step(); chk("wrap_ff", fif.if_id_pc, 8'hFF);
      step(); chk("wrap_00", fif.if_id_pc, 8'h00);

      // asynchronous reset between edges
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_valid", fif.if_id_valid, 1'b0);
      chk("arst_instr", fif.if_id_instr, 16'h0000);
      chk("arst_pc", fif.imem_addr, 8'h00);
      chk("arst_ifpc", fif.if_id_pc, 8'h00);
`ifdef FETCH_PERF_CNT_EN
      chk("arst_fcnt", fetch_count, 16'd0);
      chk("arst_scnt", stall_count, 16'd0);
`endif
      #2 rst_n = 1'b1;

      // 4 fetches and 2 stalls after reset
      step(); step();
      stall = 1'b1;
      step(); step();
      stall = 1'b0;
      step(); step();
      chk("post_rst_pc", fif.imem_addr, 8'h04);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", fetch_count, 16'd4);
      chk("perf_stall", stall_count, 16'd2);
`endif
      chk("queue_empty", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
